// File: rtl/shift_unit_pkg.sv
// Shared encodings and widths for the multicycle shifter.
// Optional rotate-right support is enabled by defining SHIFT_UNIT_ROTR_EN.
package shift_unit_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned OP_W    = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_SLL  = 3'b010,
    OP_SRL  = 3'b011,
    OP_SRA  = 3'b100,
    OP_ROTR = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Codes that are accepted from IDLE; everything else behaves as NOP.
  function automatic logic op_valid(input logic [OP_W-1:0] op);
    case (op)
      OP_LOAD, OP_SLL, OP_SRL, OP_SRA: return 1'b1;
`ifdef SHIFT_UNIT_ROTR_EN
      OP_ROTR: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/shift_step.sv
// Single-position shift of a data word by the latched operation.
// Rotate right exists only when SHIFT_UNIT_ROTR_EN is defined.
module shift_step
  import shift_unit_pkg::*;
(
  input  op_e               op_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (op_i)
      OP_SLL:  data_o = {data_i[DATA_W-2:0], 1'b0};
      OP_SRL:  data_o = {1'b0, data_i[DATA_W-1:1]};
      OP_SRA:  data_o = {data_i[DATA_W-1], data_i[DATA_W-1:1]};
`ifdef SHIFT_UNIT_ROTR_EN
      OP_ROTR: data_o = {data_i[0], data_i[DATA_W-1:1]};
`endif
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// Multicycle shifter: loads an operand, then shifts one bit per clock until the count expires.
// Define SHIFT_UNIT_ROTR_EN to accept op 3'b101 as rotate right.
module shift_unit
  import shift_unit_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [OP_W-1:0]     op,
  input  logic [SHAMT_W-1:0]  shamt,
  input  logic [DATA_W-1:0]   data_in,
  output logic [DATA_W-1:0]   data_out,
  output logic                busy,
  output logic                done
);

  state_e              state_q;
  op_e                 op_q;
  logic [SHAMT_W-1:0]  cnt_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   data_d;
  logic                busy_q;
  logic                done_q;

  shift_step u_step (
    .op_i   (op_q),
    .data_i (data_q),
    .data_o (data_d)
  );

  // Control FSM, counter and shift register; busy/done are registered with the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= OP_NOP;
      cnt_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && op_valid(op)) begin
            data_q <= data_in;
            cnt_q  <= shamt;
            op_q   <= op_e'(op);
            busy_q <= 1'b1;
            if (op == OP_LOAD || shamt == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          data_q <= data_d;
          cnt_q  <= cnt_q - SHAMT_W'(1);
          if (cnt_q == SHAMT_W'(1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out = data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_shift_unit.sv
// Scoreboard bench for shift_unit: expected results queued at accept, compared at done.
module tb_shift_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [4:0]  shamt;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  shift_unit dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .shamt    (shamt),
    .data_in  (data_in),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [4:0] s, input logic [31:0] d);
    case (o)
      3'b001: return d;
      3'b010: return d << s;
      3'b011: return d >> s;
      3'b100: return 32'($signed(d) >>> s);
      3'b101: return (s == 5'd0) ? d : ((d >> s) | (d << (32 - int'(s))));
      default: return d;
    endcase
  endfunction

  function automatic bit accepted(input logic [2:0] o);
`ifdef SHIFT_UNIT_ROTR_EN
    return (o >= 3'b001) && (o <= 3'b101);
`else
    return (o >= 3'b001) && (o <= 3'b100);
`endif
  endfunction

  // Waits for done from the negedge just after the accept edge; n counts negedges since then.
  task automatic wait_done(input string tag, input int exp_n);
    int n;
    int busy_cnt;
    n = 0;
    busy_cnt = 0;
    while (!done && n < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      n++;
    end
    if (done) busy_cnt++;
    check_eq({tag, "_lat"}, 32'(n), 32'(exp_n));
    check_eq({tag, "_busy"}, 32'(busy_cnt), 32'(exp_n + 1));
    if (exp_q.size() != 0) check_eq({tag, "_data"}, data_out, exp_q.pop_front());
    else check_eq({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [2:0] o, input logic [4:0] s, input logic [31:0] d);
    logic [31:0] hold;
    int exp_n;
    @(negedge clk);
    hold    = data_out;
    op      = o;
    shamt   = s;
    data_in = d;
    start   = 1'b1;
    if (accepted(o)) exp_q.push_back(model(o, s, d));
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    op      = 3'($urandom);
    shamt   = 5'($urandom);
    data_in = $urandom;
    if (!accepted(o)) begin
      repeat (3) @(negedge clk);
      check_eq({tag, "_noacc"}, {30'd0, busy, done}, 32'd0);
      check_eq({tag, "_hold"}, data_out, hold);
    end else begin
      exp_n = (o == 3'b001 || s == 5'd0) ? 0 : int'(s);
      wait_done(tag, exp_n);
      @(negedge clk);
      check_eq({tag, "_post"}, {30'd0, busy, done}, 32'd0);
    end
  endtask

  initial begin
    int n;
    bit seen;
    reset   = 1'b0;
    start   = 1'b0;
    op      = 3'b000;
    shamt   = 5'd0;
    data_in = 32'd0;
    #12;
    check_eq("rst_state", {data_out[29:0], busy, done}, 32'd0);
    check_eq("rst_data", data_out, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Reset in the middle of a long shift
    @(negedge clk);
    op = 3'b010; shamt = 5'd20; data_in = 32'h1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("midrst_data", data_out, 32'd0);
    check_eq("midrst_flags", {30'd0, busy, done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check_eq("midrst_quiet", 32'(seen), 32'd0);

    do_op("sll4",   3'b010, 5'd4,  32'h0000_0001);
    do_op("sra31",  3'b100, 5'd31, 32'h8000_0000);
    do_op("srl31",  3'b011, 5'd31, 32'h8000_0000);
    do_op("srl0",   3'b011, 5'd0,  32'hDEAD_BEEF);
    do_op("load",   3'b001, 5'd9,  32'hDEAD_BEEF);
    do_op("sll1",   3'b010, 5'd1,  32'hC000_0001);
    do_op("rotr1",  3'b101, 5'd1,  32'h0000_0003);
    do_op("rotr7",  3'b101, 5'd7,  32'h1234_5678);
    do_op("nop0",   3'b000, 5'd3,  32'h1111_1111);
    do_op("nop6",   3'b110, 5'd3,  32'h2222_2222);
    do_op("nop7",   3'b111, 5'd3,  32'h3333_3333);

    for (int i = 0; i < 12; i++) begin
      do_op("rand", 3'($urandom_range(2, 4)), 5'($urandom), $urandom);
    end

    // start held through DONE while shamt keeps changing
    @(negedge clk);
    op = 3'b010; shamt = 5'd2; data_in = 32'h1; start = 1'b1;
    exp_q.push_back(32'h4);
    @(posedge clk);
    n = 0;
    @(negedge clk);
    while (!done && n < 40) begin
      shamt = 5'($urandom_range(1, 31));
      data_in = $urandom;
      @(negedge clk);
      n++;
    end
    check_eq("b2b_lat1", 32'(n), 32'd2);
    check_eq("b2b_data1", data_out, exp_q.pop_front());
    shamt = 5'd3; data_in = 32'hFFFF_FFFF;
    @(negedge clk);
    check_eq("b2b_gap", {30'd0, busy, done}, 32'd0);
    shamt = 5'd5; data_in = 32'h100;
    exp_q.push_back(32'h2000);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    shamt = 5'd1;
    wait_done("b2b2", 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
